fpga_ram_2p_be: RTL and testbench
=================================

Name: fpga_ram_2p_be

Overview:
Simple dual-port FPGA block RAM with a write-only port A and a read-only port B on one clock. It is the successor to the single-port FPGA RAM wrapper and adds byte-enable writes, a configurable read latency of 1 or 2 cycles, and a read-valid pipeline. Read-during-write collisions are resolved by byte-merged forwarding. Used for C910 FPGA builds wherever a cache or buffer array needs concurrent fill and lookup.

Parameters:
DATAWIDTH, 64, data width in bits; must be a multiple of 8
ADDRWIDTH, 8, address width; depth MEMDEPTH = 2**ADDRWIDTH
READLAT, 1, read latency in cycles; legal values 1 or 2 (elaboration error otherwise)
BEWIDTH, DATAWIDTH/8, derived localparam, one enable bit per byte

Ports:
Clk  input  1  single clock, rising edge
RstB  input  1  asynchronous active-low reset
PortAAddr  input  ADDRWIDTH  write address
PortADataIn  input  DATAWIDTH  write data
PortAByteEn  input  BEWIDTH  byte write enables; bit i covers data bits [8i+7:8i]
PortAWriteEnable  input  1  write strobe
PortBAddr  input  ADDRWIDTH  read address
PortBReadEnable  input  1  read strobe
PortBDataOut  output  DATAWIDTH  read data
PortBDataValid  output  1  high for exactly one cycle per accepted read
InitBusy  output  1  memory-clear in progress (see Optional Feature)

Behaviour:
- Reset (RstB low, asynchronous): PortBDataOut = 0, PortBDataValid = 0, all pipeline stages = 0. Memory contents are not reset.
- Write: on a rising edge with PortAWriteEnable=1 and InitBusy=0, each byte i with PortAByteEn[i]=1 is written to mem[PortAAddr]. Bytes with enable 0 keep their value. PortAByteEn=0 with write enable high is a legal no-op.
- Read: a read is accepted on a rising edge with PortBReadEnable=1 and InitBusy=0.
  - READLAT=1: data is registered at that edge. PortBDataOut and PortBDataValid=1 are visible in the following cycle.
  - READLAT=2: an extra output register stage is added. Valid and data appear one cycle later.
  - The valid pipeline tracks the data pipeline exactly, so back-to-back reads give back-to-back valids.
- No read accepted: PortBDataOut holds its last value and PortBDataValid=0. The output pipeline advances every cycle and has no stall input.
- Collision: a write and a read to the same address on the same edge is a write-first, byte-merged case. Read data = enabled bytes from PortADataIn, other bytes from the old memory word. This is implemented with an explicit forward path, independent of FPGA primitive behaviour.
- Different addresses on the same edge: fully independent. A read of address X in the cycle after a write to X returns the new data.
- Reset asserted mid-read: the in-flight valid is dropped and no valid is produced for that read after reset release.
- Address wrap: none. Every address in 0..MEMDEPTH-1 is legal.

Optional Feature:
FPGA_RAM_INIT_ZERO_EN
- Defined: a two-state FSM, INIT and IDLE, is enabled.
  - On reset the FSM enters INIT with a sweep counter at 0. InitBusy=1.
  - Each cycle in INIT writes all-zero words to mem[counter] and increments the counter.
  - After writing address MEMDEPTH-1, the FSM moves to IDLE, which takes exactly MEMDEPTH cycles after reset release. InitBusy=0 in IDLE.
  - While InitBusy=1, port A writes and port B reads are ignored and no PortBDataValid is produced.
  - Reset asserted during INIT restarts the sweep at address 0.
- Not defined: there is no FSM or counter. InitBusy is tied to 0 and memory power-up contents are undefined.

Test Plan:
1. DATAWIDTH=64, READLAT=1: write 0x1122334455667788 to addr 5 with ByteEn=0xFF, then read addr 5 -> PortBDataOut=0x1122334455667788 with Valid=1 exactly one cycle after the read edge.
2. Byte-enable merge: after test 1, write 0xAAAAAAAAAAAAAAAA to addr 5 with ByteEn=0x0F, then read addr 5 -> 0x11223344AAAAAAAA.
3. Collision: addr 7 holds 0; on the same edge write 0xFFFFFFFFFFFFFFFF with ByteEn=0xF0 to addr 7 and read addr 7 -> 0xFFFFFFFF00000000 returned with Valid.
4. READLAT=2 streaming: read addrs 0,1,2 on consecutive edges -> Valid high for 3 consecutive cycles starting 2 cycles after the first read, with data in address order. Output holds and Valid=0 afterwards.
5. Reset mid-operation: issue a read, assert RstB on the next cycle -> DataOut=0 and Valid=0 immediately. No stale valid after release.
6. With FPGA_RAM_INIT_ZERO_EN, ADDRWIDTH=4: InitBusy=1 for exactly 16 cycles after reset release, and a write issued during the sweep is dropped. Afterwards, reading every address returns 0.

Source files
------------

// File: rtl/fpga_ram_2p_be.sv
// Simple dual-port block RAM: write-only port A with byte enables, read-only port B
// with 1- or 2-cycle latency. The optional zero sweep is enabled by FPGA_RAM_INIT_ZERO_EN.
module fpga_ram_2p_be #(
  parameter int DATAWIDTH = 64,
  parameter int ADDRWIDTH = 8,
  parameter int READLAT   = 1
) (
  input  logic                   Clk,
  input  logic                   RstB,
  input  logic [ADDRWIDTH-1:0]   PortAAddr,
  input  logic [DATAWIDTH-1:0]   PortADataIn,
  input  logic [DATAWIDTH/8-1:0] PortAByteEn,
  input  logic                   PortAWriteEnable,
  input  logic [ADDRWIDTH-1:0]   PortBAddr,
  input  logic                   PortBReadEnable,
  output logic [DATAWIDTH-1:0]   PortBDataOut,
  output logic                   PortBDataValid,
  output logic                   InitBusy
);

  localparam int BEWIDTH  = DATAWIDTH / 8;
  localparam int MEMDEPTH = 2 ** ADDRWIDTH;

  if (READLAT != 1 && READLAT != 2) begin : g_bad_readlat
    $error("fpga_ram_2p_be: READLAT must be 1 or 2");
  end
  if (DATAWIDTH % 8 != 0) begin : g_bad_width
    $error("fpga_ram_2p_be: DATAWIDTH must be a multiple of 8");
  end

  logic [DATAWIDTH-1:0] mem [MEMDEPTH];
  logic                 init_busy;
  logic [ADDRWIDTH-1:0] init_addr;

`ifdef FPGA_RAM_INIT_ZERO_EN
  typedef enum logic {ST_INIT, ST_IDLE} init_state_t;
  init_state_t init_state;

  // Sweep walks every address once; leaving INIT after the last one gives MEMDEPTH busy cycles.
  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      init_state <= ST_INIT;
      init_addr  <= '0;
      init_busy  <= 1'b1;
    end else if (init_state == ST_INIT) begin
      init_addr <= init_addr + 1'b1;
      if (&init_addr) begin
        init_state <= ST_IDLE;
        init_busy  <= 1'b0;
      end
    end
  end
`else
  assign init_busy = 1'b0;
  assign init_addr = '0;
`endif

  assign InitBusy = init_busy;

  logic wr_acc;
  logic rd_acc;
  assign wr_acc = PortAWriteEnable & ~init_busy;
  assign rd_acc = PortBReadEnable & ~init_busy;

  always_ff @(posedge Clk) begin
    if (init_busy) begin
      mem[init_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < BEWIDTH; i++) begin
        if (PortAByteEn[i]) mem[PortAAddr][8*i +: 8] <= PortADataIn[8*i +: 8];
      end
    end
  end

  // Write-first forwarding on a same-address collision, merged byte by byte.
  logic [DATAWIDTH-1:0] rd_word;
  always_comb begin
    rd_word = mem[PortBAddr];
    if (wr_acc && (PortAAddr == PortBAddr)) begin
      for (int i = 0; i < BEWIDTH; i++) begin
        if (PortAByteEn[i]) rd_word[8*i +: 8] = PortADataIn[8*i +: 8];
      end
    end
  end

  logic [DATAWIDTH-1:0] s1_data;
  logic                 s1_valid;

  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= rd_word;
    end
  end

  if (READLAT == 2) begin : g_lat2
    logic [DATAWIDTH-1:0] s2_data;
    logic                 s2_valid;

    always_ff @(posedge Clk or negedge RstB) begin
      if (!RstB) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign PortBDataOut   = s2_data;
    assign PortBDataValid = s2_valid;
  end else begin : g_lat1
    assign PortBDataOut   = s1_data;
    assign PortBDataValid = s1_valid;
  end

endmodule

// File: tb/tb_fpga_ram_2p_be.sv
// Bench for fpga_ram_2p_be: one READLAT=1 and one READLAT=2 instance share the stimulus
// and are checked against a per-cycle history model of accepted reads.
module tb_fpga_ram_2p_be;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic [7:0]    a_be = '0;
  logic          a_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic          b_re = 1'b0;

  logic [DW-1:0] d1, d2;
  logic          v1, v2, busy1, busy2;

  fpga_ram_2p_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .READLAT(1)) dut1 (
    .Clk(clk), .RstB(rst_n), .PortAAddr(a_addr), .PortADataIn(a_data), .PortAByteEn(a_be),
    .PortAWriteEnable(a_we), .PortBAddr(b_addr), .PortBReadEnable(b_re),
    .PortBDataOut(d1), .PortBDataValid(v1), .InitBusy(busy1));

  fpga_ram_2p_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .READLAT(2)) dut2 (
    .Clk(clk), .RstB(rst_n), .PortAAddr(a_addr), .PortADataIn(a_data), .PortAByteEn(a_be),
    .PortAWriteEnable(a_we), .PortBAddr(b_addr), .PortBReadEnable(b_re),
    .PortBDataOut(d2), .PortBDataValid(v2), .InitBusy(busy2));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // scoreboard state
  int            n_total = 0;
  int            n_pass  = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic          hist_v [$];
  logic [DW-1:0] hist_d [$];
  int            busy_left = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [7:0] be);
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  // Output seen lat cycles after a read edge: valid of that edge, data of the newest read at or before it.
  task automatic expect_at(input int lat, output logic ev, output logic [DW-1:0] ed);
    int idx;
    idx = hist_v.size() - lat;
    ev = 1'b0;
    ed = '0;
    if (idx >= 0) begin
      ev = hist_v[idx];
      for (int j = idx; j >= 0; j--) begin
        if (hist_v[j]) begin
          ed = hist_d[j];
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic          ev;
    logic [DW-1:0] ed;
    expect_at(1, ev, ed);
    chk("lat1_valid", {63'd0, v1}, {63'd0, ev});
    chk("lat1_data", d1, ed);
    expect_at(2, ev, ed);
    chk("lat2_valid", {63'd0, v2}, {63'd0, ev});
    chk("lat2_data", d2, ed);
    chk("init_busy", {62'd0, busy2, busy1}, (busy_left > 0) ? 64'd3 : 64'd0);
  endtask

  // driver: apply one cycle of inputs at the falling edge, update model at the rising edge
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [7:0] be, input logic re, input logic [AW-1:0] ra);
    logic busy;
    a_we = we; a_addr = wa; a_data = wd; a_be = be; b_re = re; b_addr = ra;
    @(posedge clk);
    busy = (busy_left > 0);
    if (busy) busy_left--;
    hist_v.push_back(re && !busy);
    hist_d.push_back((we && !busy && wa == ra) ? merge_bytes(ref_mem[ra], wd, be) : ref_mem[ra]);
    if (we && !busy) ref_mem[wa] = merge_bytes(ref_mem[wa], wd, be);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 8'h00, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid1", {63'd0, v1}, 64'd0);
    chk("rst_data1", d1, 64'd0);
    chk("rst_valid2", {63'd0, v2}, 64'd0);
    chk("rst_data2", d2, 64'd0);
    hist_v.delete();
    hist_d.delete();
`ifdef FPGA_RAM_INIT_ZERO_EN
    busy_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
    busy_left = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [7:0]    be;
    logic          re;
    logic [AW-1:0] ra;
    logic          ev;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic          cap_v [5];
    logic [DW-1:0] cap_d [5];
    int            cnt;

    tbl[0] = '{1'b1, 4'd5, 64'h1122334455667788, 8'hFF, 1'b0, 4'd0, 1'b0, 64'h0};
    tbl[1] = '{1'b0, 4'd0, 64'h0,                8'h00, 1'b1, 4'd5, 1'b1, 64'h1122334455667788};
    tbl[2] = '{1'b1, 4'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 4'd0, 1'b0, 64'h0};
    tbl[3] = '{1'b0, 4'd0, 64'h0,                8'h00, 1'b1, 4'd5, 1'b1, 64'h11223344AAAAAAAA};
    tbl[4] = '{1'b1, 4'd7, 64'h0,                8'hFF, 1'b0, 4'd0, 1'b0, 64'h0};
    tbl[5] = '{1'b1, 4'd7, 64'hFFFFFFFFFFFFFFFF, 8'hF0, 1'b1, 4'd7, 1'b1, 64'hFFFFFFFF00000000};
    tbl[6] = '{1'b0, 4'd0, 64'h0,                8'h00, 1'b1, 4'd7, 1'b1, 64'hFFFFFFFF00000000};
    tbl[7] = '{1'b1, 4'd5, 64'h0,                8'h00, 1'b1, 4'd5, 1'b1, 64'h11223344AAAAAAAA};
    tbl[8] = '{1'b1, 4'd3, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 4'd5, 1'b1, 64'h11223344AAAAAAAA};
    tbl[9] = '{1'b0, 4'd0, 64'h0,                8'h00, 1'b1, 4'd3, 1'b1, 64'h0123456789ABCDEF};

    @(negedge clk);
    do_reset();

`ifdef FPGA_RAM_INIT_ZERO_EN
    // Sweep: a write attempted while busy must be dropped; busy lasts exactly DEPTH cycles.
    cnt = 0;
    step(1'b1, 4'd2, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b0, '0);
    cnt++;
    while (busy1 && cnt < 100) begin
      idle();
      cnt++;
    end
    chk("init_busy_cycles", 64'(cnt), 64'd16);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, '0, 8'h00, 1'b1, AW'(i));
      chk($sformatf("init_zero_%0d", i), d1, 64'd0);
    end
`else
    cnt = 0;
`endif

    // preload every word so the model knows the whole array
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), {$urandom, $urandom}, 8'hFF, 1'b0, '0);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra);
      chk($sformatf("tbl%0d_valid", i), {63'd0, v1}, {63'd0, tbl[i].ev});
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), d1, tbl[i].ed);
    end

    // latency-2 streaming of three back-to-back reads
    for (int i = 0; i < 3; i++) step(1'b1, AW'(i), 64'hA0A0A0A0A0A0A0A0 + 64'(i), 8'hFF, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1'b0, '0, '0, 8'h00, 1'b1, AW'(i));
      else idle();
      cap_v[i] = v2;
      cap_d[i] = d2;
    end
    chk("stream_v", {59'd0, cap_v[0], cap_v[1], cap_v[2], cap_v[3], cap_v[4]}, 64'b01110);
    chk("stream_d0", cap_d[1], 64'hA0A0A0A0A0A0A0A0);
    chk("stream_d1", cap_d[2], 64'hA0A0A0A0A0A0A0A1);
    chk("stream_d2", cap_d[3], 64'hA0A0A0A0A0A0A0A2);
    chk("stream_hold", cap_d[4], 64'hA0A0A0A0A0A0A0A2);

    // reset with a read in flight: nothing may surface after release
    step(1'b0, '0, '0, 8'h00, 1'b1, 4'd1);
    chk("pre_rst_valid", {63'd0, v1}, 64'd1);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (v1 || v2) cnt++;
    end
    chk("post_rst_no_valid", 64'(cnt), 64'd0);

    // randomized traffic, narrow address range to force collisions
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), {$urandom, $urandom},
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 3; i++) idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
